// File: rtl/tile_map_write_arbiter.sv
// rtl/tile_map_write_arbiter.sv - round-robin tile-map write arbiter gated to vertical blanking
module tile_map_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4,
  parameter int MAX_WR = 64
) (
  input  logic                      clk_25m,
  input  logic                      rst,
  input  logic                      vblank,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      busy,
  output logic [7:0]                wr_count,
  output logic                      miss
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_WR);

  typedef enum logic [1:0] {IDLE, ARB, WRITE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               miss_q, miss_d;
  logic               busy_q, busy_d;
  logic               vblank_d_q;
  logic               armed_q, armed_d;
  logic               rise, fall;
  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;

  // A rise only counts once vblank has been seen low since reset, so a reset
  // released in the middle of a blank does not open a write window.
  assign rise = vblank & ~vblank_d_q & armed_q;
  assign fall = ~vblank & vblank_d_q;

  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ack_d   = ack_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    armed_d = armed_q | ~vblank;
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = ARB;
        end
      end
      ARB: begin
        if (!vblank) begin
          state_d = IDLE;
        end else if (cnt_q == MAX_CNT) begin
          state_d = HOLD;
        end else if (grant_vld) begin
          addr_d  = req_addr[grant_idx*ADDR_W +: ADDR_W];
          data_d  = req_data[grant_idx*DATA_W +: DATA_W];
          we_d    = 1'b1;
          ack_d   = N_REQ'(1) << grant_idx;
          ptr_d   = PTR_W'((int'(grant_idx) + 1) % N_REQ);
          state_d = WRITE;
        end
      end
      WRITE: begin
        we_d  = 1'b0;
        ack_d = '0;
        if (cnt_q != MAX_CNT) cnt_d = cnt_q + 8'd1;
        state_d = vblank ? ARB : IDLE;
      end
      HOLD: begin
        if (!vblank) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rise) miss_d = 1'b0;
    if (fall && (|req)) miss_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      ack_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      miss_q     <= 1'b0;
      busy_q     <= 1'b0;
      vblank_d_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ack_q      <= ack_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      busy_q     <= busy_d;
      vblank_d_q <= vblank;
      armed_q    <= armed_d;
    end
  end

  assign ack      = ack_q;
  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign busy     = busy_q;
  assign wr_count = cnt_q;
  assign miss     = miss_q;

endmodule

// File: tb/tb_tile_map_write_arbiter.sv
// tb/tb_tile_map_write_arbiter.sv - scoreboard bench for tile_map_write_arbiter
module tb_tile_map_write_arbiter;

  localparam int N = 4;
  localparam int AW = 12;
  localparam int DW = 4;

  logic            clk_25m = 1'b0;
  logic            rst;
  logic            vblank;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data;
  logic            busy;
  logic [7:0]      wr_count;
  logic            miss;

  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int prev_cyc = 0;
  int last_wr_cyc = 0;
  int c0 = 0;
  bit have_prev = 0;
  bit spacing_on = 0;
  bit keep_req = 0;
  bit drop_vb_on_we = 0;
  bit rst_on_we = 0;

  always #20 clk_25m = ~clk_25m;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  tile_map_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_WR(4)) dut (
    .clk_25m  (clk_25m),
    .rst      (rst),
    .vblank   (vblank),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .busy     (busy),
    .wr_count (wr_count),
    .miss     (miss)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.idx  = i;
    e.addr = a[i];
    e.data = d[i];
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk_25m);
    if (ram_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", ram_we, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack", ack, 32'(1) << e.idx);
        chk("ram_addr", ram_addr, e.addr);
        chk("ram_data", ram_data, e.data);
        if (spacing_on && have_prev) chk("spacing", cyc - prev_cyc, 2);
        prev_cyc = cyc;
        have_prev = 1;
        last_wr_cyc = cyc;
        if (!keep_req) req[e.idx] = 1'b0;
      end
      if (drop_vb_on_we) begin
        vblank = 1'b0;
        drop_vb_on_we = 0;
      end
      if (rst_on_we) begin
        rst = 1'b1;
        #1;
        chk("rst_we", ram_we, 0);
        chk("rst_ack", ack, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_miss", miss, 0);
        chk("rst_busy", busy, 0);
        rst_on_we = 0;
      end
    end else if (ack != '0) begin
      chk("ack_without_we", ack, 0);
    end
    @(posedge clk_25m);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    vblank = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(100 * i + 7);
      d[i] = DW'(i + 8);
    end
    a[0] = 12'd130;
    d[0] = 4'h5;
    @(posedge clk_25m); #1;
    @(posedge clk_25m); #1;
    chk("reset_we", ram_we, 0);
    chk("reset_ack", ack, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_count", wr_count, 0);
    chk("reset_miss", miss, 0);
    chk("reset_addr", ram_addr, 0);
    chk("reset_data", ram_data, 0);
    rst = 1'b0;
    run(2);

    // single request, nothing before blank
    req = 4'b0001;
    run(3);
    push_exp(0);
    c0 = cyc;
    vblank = 1'b1;
    run(4);
    chk("single_pending", exp_q.size(), 0);
    chk("first_latency", last_wr_cyc - c0, 2);
    chk("single_wr_count", wr_count, 1);
    chk("single_busy", busy, 1);
    vblank = 1'b0;
    run(2);
    chk("single_idle_busy", busy, 0);
    chk("single_miss", miss, 0);

    // round-robin over all requesters, cap of 4 reached
    a[0] = 12'd7;
    d[0] = 4'd8;
    keep_req = 1;
    spacing_on = 1;
    have_prev = 0;
    req = 4'b1111;
    push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    vblank = 1'b1;
    run(14);
    chk("rr_pending", exp_q.size(), 0);
    chk("rr_wr_count", wr_count, 4);
    chk("rr_hold_busy", busy, 1);
    chk("rr_hold_we", ram_we, 0);
    vblank = 1'b0;
    run(2);
    chk("rr_miss", miss, 1);
    chk("rr_busy_after", busy, 0);
    chk("rr_count_kept", wr_count, 4);

    // budget cap with two requesters, pointer wraps
    have_prev = 0;
    req = 4'b0011;
    push_exp(1); push_exp(0); push_exp(1); push_exp(0);
    vblank = 1'b1;
    run(14);
    chk("cap_pending", exp_q.size(), 0);
    chk("cap_wr_count", wr_count, 4);
    chk("cap_busy", busy, 1);
    chk("cap_miss_cleared", miss, 0);
    vblank = 1'b0;
    run(2);
    chk("cap_miss", miss, 1);

    // blank ends while in WRITE
    spacing_on = 0;
    req = 4'b0001;
    push_exp(0);
    drop_vb_on_we = 1;
    vblank = 1'b1;
    run(6);
    chk("mid_pending", exp_q.size(), 0);
    chk("mid_busy", busy, 0);
    chk("mid_miss", miss, 1);
    chk("mid_wr_count", wr_count, 1);
    req = '0;
    vblank = 1'b1;
    run(1);
    chk("rise_clr_miss", miss, 0);
    chk("rise_clr_count", wr_count, 0);
    vblank = 1'b0;
    run(2);

    // single-cycle blank: no write
    req = 4'b0001;
    vblank = 1'b1;
    run(1);
    vblank = 1'b0;
    run(4);
    chk("short_busy", busy, 0);
    chk("short_wr_count", wr_count, 0);
    chk("short_miss", miss, 1);
    req = '0;

    // reset in the middle of a write
    req = 4'b0100;
    push_exp(2);
    rst_on_we = 1;
    vblank = 1'b1;
    run(5);
    chk("rst_seen", rst_on_we, 0);
    rst = 1'b0;
    run(6);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_wr_count", wr_count, 0);
    vblank = 1'b0;
    run(2);
    keep_req = 0;
    push_exp(2);
    vblank = 1'b1;
    run(5);
    chk("post_rst_pending", exp_q.size(), 0);
    vblank = 1'b0;
    run(2);

    // pointer persists: last grant was 2, next frame starts at 3
    keep_req = 1;
    req = 4'b1111;
    push_exp(3); push_exp(0); push_exp(1); push_exp(2);
    vblank = 1'b1;
    run(12);
    chk("ptr_pending", exp_q.size(), 0);
    vblank = 1'b0;
    req = '0;
    run(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
